// File: rtl/cheat_pkg.sv
// Shared constants for the cheat patch engine: programming word layout and address width.
// Compare support is controlled by the CHEAT_COMPARE_EN macro in the slot and top files.
package cheat_pkg;

  localparam int ADDR_W = 24;

  // Slot word 1 bit positions
  localparam int W1_EN      = 0;
  localparam int W1_CMP_EN  = 1;
  localparam int W1_ONESHOT = 2;
  localparam int W1_CMP_LSB = 8;

  // Control word bit positions
  localparam int CTL_GEN_SET = 0;
  localparam int CTL_CNT_CLR = 1;
  localparam int CTL_GEN_CLR = 8;

  typedef enum logic {
    SEL_ADDR_DATA = 1'b0,
    SEL_FLAGS     = 1'b1
  } pgm_sel_e;

endpackage

// File: rtl/cheat_patch_engine_if.sv
// SNES-side bus of the cheat patch engine.
// Strobes carry no valid/ready handshake: SNES_cycle_start and SNES_rd_strobe are
// single-clk pulses; cheat_hit qualifies data_out on the same clk.
interface cheat_patch_engine_if;
  import cheat_pkg::*;

  logic [ADDR_W-1:0] SNES_ADDR;
  logic              SNES_cycle_start;
  logic              SNES_rd_strobe;
  logic [7:0]        rom_data_in;
  logic [7:0]        data_out;
  logic              cheat_hit;

  modport master (
    output SNES_ADDR, SNES_cycle_start, SNES_rd_strobe, rom_data_in,
    input  data_out, cheat_hit
  );

  modport slave (
    input  SNES_ADDR, SNES_cycle_start, SNES_rd_strobe, rom_data_in,
    output data_out, cheat_hit
  );
endinterface

// File: rtl/cheat_slot.sv
// One patch slot: address/data registers, flags, saturating hit counter, one-shot clear.
// Compare registers exist only when CHEAT_COMPARE_EN is defined.
module cheat_slot
  import cheat_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pgm_we,
  input  logic              pgm_sel,
  input  logic [31:0]       pgm_in,
  input  logic [ADDR_W-1:0] addr,
  input  logic              global_en,
  input  logic              cnt_clr,
  input  logic              rd_win,
  output logic              match,
  output logic [7:0]        data,
  output logic              oneshot_fire,
`ifdef CHEAT_COMPARE_EN
  output logic              cmp_en,
  output logic [7:0]        cmp_val,
`endif
  output logic [CNT_W-1:0]  count
);

  logic [ADDR_W-1:0] addr_q;
  logic [7:0]        data_q;
  logic              en_q;
  logic              oneshot_q;

  assign match        = en_q && global_en && (addr == addr_q);
  assign data         = data_q;
  // Programming in the same clk as the read strobe suppresses the one-shot clear.
  assign oneshot_fire = rd_win && oneshot_q && !pgm_we;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      addr_q    <= '0;
      data_q    <= '0;
      en_q      <= 1'b0;
      oneshot_q <= 1'b0;
    end else if (pgm_we) begin
      if (pgm_sel == SEL_ADDR_DATA) begin
        addr_q <= pgm_in[31:8];
        data_q <= pgm_in[7:0];
      end else begin
        en_q      <= pgm_in[W1_EN];
        oneshot_q <= pgm_in[W1_ONESHOT];
      end
    end else if (oneshot_fire) begin
      en_q <= 1'b0;
    end
  end

`ifdef CHEAT_COMPARE_EN
  logic       cmp_en_q;
  logic [7:0] cmp_val_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cmp_en_q  <= 1'b0;
      cmp_val_q <= '0;
    end else if (pgm_we && pgm_sel == SEL_FLAGS) begin
      cmp_en_q  <= pgm_in[W1_CMP_EN];
      cmp_val_q <= pgm_in[W1_CMP_LSB +: 8];
    end
  end

  assign cmp_en  = cmp_en_q;
  assign cmp_val = cmp_val_q;
`endif

  // Counter clear beats increment; reprogramming the slot drops the increment.
  always_ff @(posedge clk) begin
    if (!rst_n || cnt_clr) begin
      count <= '0;
    end else if (rd_win && !pgm_we && (count != {CNT_W{1'b1}})) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/cheat_patch_engine.sv
// Parametrised ROM patch engine: SLOTS address/data patches with priority select,
// two-stage hit pipeline and control word. Optional compare gated by CHEAT_COMPARE_EN.
module cheat_patch_engine
  import cheat_pkg::*;
#(
  parameter int SLOTS = 16,
  parameter int CNT_W = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  cheat_patch_engine_if.slave      snes,
  input  logic                     pgm_we,
  input  logic [$clog2(SLOTS):0]   pgm_idx,
  input  logic                     pgm_sel,
  input  logic [31:0]              pgm_in,
  input  logic [$clog2(SLOTS)-1:0] cnt_idx,
  output logic [CNT_W-1:0]         hit_count
);

  localparam int IDX_W = $clog2(SLOTS);

  logic             global_en;
  logic             ctl_we;
  logic             cnt_clr;
  logic [SLOTS-1:0] slot_match;
  logic [SLOTS-1:0] slot_fire;
  logic [7:0]       slot_data [SLOTS];
  logic [CNT_W-1:0] slot_cnt  [SLOTS];

  logic             win_any;
  logic [IDX_W-1:0] win_idx;
  logic             s1_hit;
  logic [IDX_W-1:0] s1_idx;
  logic [7:0]       s1_data;
  logic             cmp_ok;

`ifdef CHEAT_COMPARE_EN
  logic             slot_cmp_en  [SLOTS];
  logic [7:0]       slot_cmp_val [SLOTS];
  logic             s1_cmp_en;
  logic [7:0]       s1_cmp_val;
`endif

  assign ctl_we  = pgm_we && (pgm_idx == (IDX_W+1)'(SLOTS));
  assign cnt_clr = ctl_we && pgm_in[CTL_CNT_CLR];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      global_en <= 1'b0;
    end else if (ctl_we) begin
      if (pgm_in[CTL_GEN_CLR])      global_en <= 1'b0;
      else if (pgm_in[CTL_GEN_SET]) global_en <= 1'b1;
    end
  end

  for (genvar g = 0; g < SLOTS; g++) begin : g_slot
    logic slot_we;
    logic rd_win;

    assign slot_we = pgm_we && (pgm_idx == (IDX_W+1)'(g));
    assign rd_win  = snes.SNES_rd_strobe && snes.cheat_hit && (s1_idx == IDX_W'(g));

    cheat_slot #(.CNT_W(CNT_W)) u_slot (
      .clk          (clk),
      .rst_n        (rst_n),
      .pgm_we       (slot_we),
      .pgm_sel      (pgm_sel),
      .pgm_in       (pgm_in),
      .addr         (snes.SNES_ADDR),
      .global_en    (global_en),
      .cnt_clr      (cnt_clr),
      .rd_win       (rd_win),
      .match        (slot_match[g]),
      .data         (slot_data[g]),
      .oneshot_fire (slot_fire[g]),
`ifdef CHEAT_COMPARE_EN
      .cmp_en       (slot_cmp_en[g]),
      .cmp_val      (slot_cmp_val[g]),
`endif
      .count        (slot_cnt[g])
    );
  end

  // Lowest index wins: scan downward so the last assignment is the lowest match.
  always_comb begin
    win_any = 1'b0;
    win_idx = '0;
    for (int i = SLOTS - 1; i >= 0; i--) begin
      if (slot_match[i]) begin
        win_any = 1'b1;
        win_idx = IDX_W'(i);
      end
    end
  end

  // Stage 1 holds the winner for the whole bus cycle; a one-shot firing drops the hit.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_hit     <= 1'b0;
      s1_idx     <= '0;
      s1_data    <= '0;
`ifdef CHEAT_COMPARE_EN
      s1_cmp_en  <= 1'b0;
      s1_cmp_val <= '0;
`endif
    end else if (snes.SNES_cycle_start) begin
      s1_hit     <= win_any;
      s1_idx     <= win_idx;
      s1_data    <= win_any ? slot_data[win_idx] : 8'h00;
`ifdef CHEAT_COMPARE_EN
      s1_cmp_en  <= win_any && slot_cmp_en[win_idx];
      s1_cmp_val <= slot_cmp_val[win_idx];
`endif
    end else if (|slot_fire) begin
      s1_hit <= 1'b0;
    end
  end

`ifdef CHEAT_COMPARE_EN
  assign cmp_ok = !s1_cmp_en || (snes.rom_data_in == s1_cmp_val);
`else
  assign cmp_ok = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      snes.cheat_hit <= 1'b0;
      snes.data_out  <= '0;
      hit_count      <= '0;
    end else begin
      snes.cheat_hit <= s1_hit && cmp_ok;
      snes.data_out  <= s1_data;
      hit_count      <= ({1'b0, cnt_idx} < (IDX_W+1)'(SLOTS)) ? slot_cnt[cnt_idx] : '0;
    end
  end

endmodule
